// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: round-robin arbiter sharing the device bus (DM bridge, timer0, timer1)
// between the CPU MEM-stage data port (m0) and the DMA/debug port (m1).
// Each grant runs one latency-counted access and returns a one-cycle ack with read data.
// Optional feature: define DEV_ARB_LOCK_EN to add m0_lock and the LOCKED state, which
// reserves the bus for m0 across an atomic read-modify-write sequence.
module dev_bus_arbiter #(
  parameter int unsigned DM_LAT   = 1,
  parameter int unsigned DEV_LAT  = 2,
  parameter logic [31:0] BAD_DATA = 32'hbbbbbbbb
) (
  input  logic        clk,
  input  logic        reset_n,
  // master 0: CPU data port
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_byteen,
`ifdef DEV_ARB_LOCK_EN
  input  logic        m0_lock,
`endif
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rd,
  // master 1: DMA/debug port
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rd,
  // CPU exception entry: blocks new m1 grants
  input  logic        int_req,
  // bridge side
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wd,
  output logic [3:0]  dev_byteen,
  input  logic [31:0] dev_rd,
  output logic        gnt_id
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBusy   = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
`ifdef DEV_ARB_LOCK_EN
  localparam logic [1:0] StLocked = 2'd3;
`endif

  localparam logic [1:0] RegDm  = 2'd0;
  localparam logic [1:0] RegTmr = 2'd1;
  localparam logic [1:0] RegBad = 2'd2;

  localparam logic [3:0] DmCnt  = 4'(DM_LAT);
  localparam logic [3:0] DevCnt = 4'(DEV_LAT);

  // Address map: DM below 0x3000, two 12-byte timer windows, everything else unmapped.
  function automatic logic [1:0] decode(input logic [31:0] a);
    if (a < 32'h0000_3000) begin
      return RegDm;
    end else if ((a >= 32'h0000_7f00 && a <= 32'h0000_7f0b) ||
                 (a >= 32'h0000_7f10 && a <= 32'h0000_7f1b)) begin
      return RegTmr;
    end else begin
      return RegBad;
    end
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_id_q;
  logic [29:0] addr_q;
  logic [31:0] wd_q;
  logic [3:0]  be_q;
  logic [1:0]  region_q;
  logic        first_q;
  logic [31:0] m0_rd_q, m1_rd_q;
`ifdef DEV_ARB_LOCK_EN
  logic [3:0]  wdog_q;
`endif

  logic        m1_elig;
  logic        gnt_valid;
  logic        gnt_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic [3:0]  req_be;
  logic [1:0]  req_region;
  logic        busy_last;

  // Grant decision: round-robin in IDLE, m0-only while LOCKED.
  always_comb begin
    m1_elig   = m1_req & ~int_req;
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    case (state_q)
      StIdle: begin
        if (m0_req && m1_elig) begin
          gnt_valid = 1'b1;
          gnt_sel   = ~gnt_id_q;
        end else if (m0_req) begin
          gnt_valid = 1'b1;
          gnt_sel   = 1'b0;
        end else if (m1_elig) begin
          gnt_valid = 1'b1;
          gnt_sel   = 1'b1;
        end
      end
`ifdef DEV_ARB_LOCK_EN
      StLocked: begin
        if (m0_req) begin
          gnt_valid = 1'b1;
          gnt_sel   = 1'b0;
        end
      end
`endif
      default: begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
      end
    endcase
  end

  // Payload of the master being granted this cycle, plus its region.
  always_comb begin
    req_addr   = gnt_sel ? m1_addr   : m0_addr;
    req_wd     = gnt_sel ? m1_wd     : m0_wd;
    req_be     = gnt_sel ? m1_byteen : m0_byteen;
    req_region = decode(req_addr);
  end

  assign busy_last = (state_q == StBusy) && (cnt_q == 4'd1);

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          if (req_region == RegBad) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = (req_region == RegDm) ? DmCnt : DevCnt;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef DEV_ARB_LOCK_EN
        // An m0 completion with lock held keeps the bus reserved for m0.
        if (!gnt_id_q && m0_lock) begin
          state_d = StLocked;
        end
`endif
      end
`ifdef DEV_ARB_LOCK_EN
      StLocked: begin
        if (gnt_valid) begin
          if (req_region == RegBad) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = (req_region == RegDm) ? DmCnt : DevCnt;
          end
        end else if (wdog_q == 4'hf) begin
          // 16th consecutive idle cycle from m0: give up the lock.
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transaction latches captured at grant; first_q marks the single write-strobe cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_id_q <= 1'b1;
      addr_q   <= 30'd0;
      wd_q     <= 32'd0;
      be_q     <= 4'd0;
      region_q <= RegDm;
      first_q  <= 1'b0;
    end else if (gnt_valid) begin
      gnt_id_q <= gnt_sel;
      addr_q   <= req_addr[31:2];
      wd_q     <= req_wd;
      be_q     <= req_be;
      region_q <= req_region;
      first_q  <= 1'b1;
    end else if (state_q == StBusy) begin
      first_q  <= 1'b0;
    end
  end

  // Per-master read data: bridge data on the last BUSY cycle, BAD_DATA for unmapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rd_q <= 32'd0;
      m1_rd_q <= 32'd0;
    end else if (gnt_valid && (req_region == RegBad)) begin
      if (gnt_sel) begin
        m1_rd_q <= BAD_DATA;
      end else begin
        m0_rd_q <= BAD_DATA;
      end
    end else if (busy_last) begin
      if (gnt_id_q) begin
        m1_rd_q <= dev_rd;
      end else begin
        m0_rd_q <= dev_rd;
      end
    end
  end

`ifdef DEV_ARB_LOCK_EN
  // Watchdog: consecutive LOCKED cycles without an m0 request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= 4'd0;
    end else if (state_q == StLocked && !m0_req) begin
      wdog_q <= wdog_q + 4'd1;
    end else begin
      wdog_q <= 4'd0;
    end
  end
`endif

  // Outputs: acks come straight from DONE so reset clears them immediately.
  always_comb begin
    m0_ack     = (state_q == StDone) & ~gnt_id_q;
    m1_ack     = (state_q == StDone) &  gnt_id_q;
    m0_err     = m0_ack & (region_q == RegBad);
    m1_err     = m1_ack & (region_q == RegBad);
    m0_rd      = m0_rd_q;
    m1_rd      = m1_rd_q;
    dev_addr   = {addr_q, 2'b00};
    dev_wd     = wd_q;
    dev_byteen = ((state_q == StBusy) && first_q) ? be_q : 4'd0;
    gnt_id     = gnt_id_q;
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Scoreboard bench for dev_bus_arbiter (default parameters DM_LAT=1, DEV_LAT=2).
// Stimulus pushes expected acks (owner, err, rd, cycle) and a negedge monitor checks them.
module tb_dev_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, int_req;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic [31:0] dev_addr, dev_wd, dev_rd;
  logic [3:0]  dev_byteen;
  logic        gnt_id;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  dev_bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wd      (m0_wd),
    .m0_byteen  (m0_byteen),
`ifdef DEV_ARB_LOCK_EN
    .m0_lock    (1'b0),
`endif
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m0_rd      (m0_rd),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_wd      (m1_wd),
    .m1_byteen  (m1_byteen),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m1_rd      (m1_rd),
    .int_req    (int_req),
    .dev_addr   (dev_addr),
    .dev_wd     (dev_wd),
    .dev_byteen (dev_byteen),
    .dev_rd     (dev_rd),
    .gnt_id     (gnt_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      tests++;
      if (m0_ack && m1_ack) begin
        fails++;
        $display("FAIL both_ack: m0_ack=1 m1_ack=1 at cycle %0d, required at most one", cyc);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: m1_ack=%0b at cycle %0d, none required", m1_ack, cyc);
      end else begin
        e = sb.pop_front();
        if (m1_ack !== e.id || (m1_ack ? m1_err : m0_err) !== e.err ||
            (m1_ack ? m1_rd : m0_rd) !== e.rd || cyc != e.cyc) begin
          fails++;
          $display("FAIL ack: got id=%0b err=%0b rd=%h cyc=%0d, required id=%0b err=%0b rd=%h cyc=%0d",
                   m1_ack, (m1_ack ? m1_err : m0_err), (m1_ack ? m1_rd : m0_rd), cyc,
                   e.id, e.err, e.rd, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One single-master transaction; lat is grant-to-ack cycles. Records bridge write strobes.
  task automatic xact(input logic id, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] rdata, input int lat,
                      input logic err, input logic [31:0] rd_exp,
                      output int pulses, output logic [3:0] pbe,
                      output logic [31:0] paddr, output logic [31:0] pwd);
    bit got;
    dev_rd = rdata;
    if (id) begin
      m1_req = 1'b1; m1_addr = addr; m1_wd = wd; m1_byteen = be;
    end else begin
      m0_req = 1'b1; m0_addr = addr; m0_wd = wd; m0_byteen = be;
    end
    sb.push_back('{id, err, rd_exp, cyc + lat});
    pulses = 0; pbe = 4'd0; paddr = 32'd0; pwd = 32'd0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (dev_byteen != 4'd0) begin
        pulses++; pbe = dev_byteen; paddr = dev_addr; pwd = dev_wd;
      end
      if (id ? m1_ack : m0_ack) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL ack_timeout: master %0b got no ack in 20 cycles, required one", id);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
  endtask

  // Boundary / unmapped vectors: master, address, grant-to-ack latency, err.
  logic        v_id  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] v_addr[7] = '{32'h5000, 32'h2ffc, 32'h3000, 32'h7f18, 32'h7f0c, 32'h7f1c,
                             32'h7f1b};
  int          v_lat [7] = '{1, 2, 1, 3, 1, 1, 3};
  logic        v_err [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int          p, bad, c;
    logic [3:0]  pb;
    logic [31:0] pa, pw, data;
    bit          got;

    reset_n = 1'b0;
    m0_req = 1'b0; m0_addr = '0; m0_wd = '0; m0_byteen = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wd = '0; m1_byteen = '0;
    int_req = 1'b0; dev_rd = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_m0_rd", m0_rd, 32'd0);
    chk("rst_m1_rd", m1_rd, 32'd0);
    chk("rst_dev_addr", dev_addr, 32'd0);
    chk("rst_dev_wd", dev_wd, 32'd0);
    chk("rst_dev_byteen", {28'd0, dev_byteen}, 32'd0);
    chk("rst_gnt_id", {31'd0, gnt_id}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // m0 DM read
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, p, pb, pa, pw);
    chk("t1_no_strobe", p, 32'd0);
    chk("t1_gnt_id", {31'd0, gnt_id}, 32'd0);
    chk("t1_m0_rd", m0_rd, 32'h1234_5678);

    // m1 timer write: exactly one strobe
    xact(1'b1, 32'h7f04, 32'hdead_beef, 4'hf, 32'h55aa_55aa, 3, 1'b0, 32'h55aa_55aa,
         p, pb, pa, pw);
    chk("t3_strobe_count", p, 32'd1);
    chk("t3_strobe_be", {28'd0, pb}, 32'hf);
    chk("t3_dev_addr", pa, 32'h7f04);
    chk("t3_dev_wd", pw, 32'hdead_beef);
    chk("t3_gnt_id", {31'd0, gnt_id}, 32'd1);

    // Contention: both request DM continuously; m0 first since m1 owned the last transaction
    c = cyc;
    dev_rd = 32'hcafe_0001;
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_byteen = 4'h0;
    sb.push_back('{1'b0, 1'b0, 32'hcafe_0001, c + 2});
    sb.push_back('{1'b1, 1'b0, 32'hcafe_0001, c + 5});
    sb.push_back('{1'b0, 1'b0, 32'hcafe_0001, c + 8});
    sb.push_back('{1'b1, 1'b0, 32'hcafe_0001, c + 11});
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cyc == c + 8) m0_req = 1'b0;
      if (cyc == c + 11) m1_req = 1'b0;
    end
    chk("t2_all_acked", sb.size(), 32'd0);
    chk("t2_gnt_id", {31'd0, gnt_id}, 32'd1);

    // Address-map boundaries and unmapped accesses
    for (int i = 0; i < 7; i++) begin
      data = 32'h1000_0000 + 32'(i);
      xact(v_id[i], v_addr[i], 32'h0, 4'h0, data, v_lat[i], v_err[i],
           v_err[i] ? 32'hbbbb_bbbb : data, p, pb, pa, pw);
      chk("map_no_strobe", p, 32'd0);
    end
    chk("map_gnt_id", {31'd0, gnt_id}, 32'd0);

    // int_req blocks new m1 grants, but not an in-flight one
    dev_rd = 32'h0000_0077;
    m1_req = 1'b1; m1_addr = 32'h40; m1_byteen = 4'h0;
    int_req = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m1_ack || gnt_id !== 1'b0 || dev_byteen != 4'd0) bad++;
    end
    chk("t5_blocked_cycles", bad, 32'd0);
    int_req = 1'b0;
    sb.push_back('{1'b1, 1'b0, 32'h0000_0077, cyc + 2});
    tick();
    chk("t5_granted", {31'd0, gnt_id}, 32'd1);
    int_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (m1_ack) got = 1'b1;
      else tick();
    end
    chk("t5_ack_seen", {31'd0, got}, 32'd1);
    m1_req = 1'b0;
    int_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write
    m0_req = 1'b1; m0_addr = 32'h20; m0_wd = 32'h1122_3344; m0_byteen = 4'h3;
    tick();
    chk("t6_strobe", {28'd0, dev_byteen}, 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_byteen", {28'd0, dev_byteen}, 32'd0);
    chk("t6_rst_dev_addr", dev_addr, 32'd0);
    chk("t6_rst_dev_wd", dev_wd, 32'd0);
    chk("t6_rst_gnt_id", {31'd0, gnt_id}, 32'd1);
    chk("t6_rst_m0_rd", m0_rd, 32'd0);
    chk("t6_rst_m1_rd", m1_rd, 32'd0);
    chk("t6_rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dev_byteen != 4'd0 || m0_ack || m1_ack) bad++;
    end
    chk("t6_quiet_after_reset", bad, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
